tcm_port_arb: RTL and testbench
===============================

TCM_PORT_ARB -- requirements
Module: tcm_port_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive denied cycles after which port B is force-granted (legal range 1..255).
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 a_valid_i / a_addr_i / a_data_i / a_wr_i  input  1/13/64/8  port A (CPU) request: valid, 64-bit word address, write data, byte write enables (all 0 = read).
REQ-005 a_accept_o  output  1  port A request taken this cycle.
REQ-006 a_resp_valid_o / a_resp_data_o  output  1/64  port A response strobe and read data.
REQ-007 b_valid_i / b_addr_i / b_data_i / b_wr_i  input  1/13/64/8  port B (external/DMA) request, same encoding as port A.
REQ-008 b_lock_i  input  1  port B requests the grant be held for its next request (atomic read-modify-write).
REQ-009 b_accept_o / b_resp_valid_o / b_resp_data_o  output  1/1/64  port B accept, response strobe, read data.
REQ-010 ram_addr_o / ram_data_o / ram_wr_o  output  13/64/8  drive the shared RAM port.
REQ-011 ram_data_i  input  64  RAM read data, valid one cycle after address, read-first.

Function
REQ-012 Each cycle, at most one of a_accept_o, b_accept_o SHALL be 1; accept is combinational from valid and arbiter state.
REQ-013 State ARB_NORMAL: A SHALL have priority; B accepted only if a_valid_i=0, or starve_cnt = STARVE_LIMIT.
REQ-014 starve_cnt (8-bit) SHALL increment, saturating at STARVE_LIMIT, each cycle b_valid_i=1 and b_accept_o=0; it SHALL clear to 0 on any B accept or any cycle b_valid_i=0.
REQ-015 When b_accept_o=1 and b_lock_i=1, next state SHALL be ARB_B_LOCK; otherwise it remains ARB_NORMAL.
REQ-016 ARB_B_LOCK: B SHALL have absolute priority and A SHALL be refused; exit to ARB_NORMAL on a B accept with b_lock_i=0, or on any cycle b_valid_i=0.
REQ-017 Lock hold limit: after STARVE_LIMIT consecutive cycles in ARB_B_LOCK with a_valid_i=1, the state SHALL return to ARB_NORMAL and A SHALL be accepted next.
REQ-018 ram_addr_o/ram_data_o/ram_wr_o SHALL present the accepted request's fields in the accept cycle; with no accept, ram_wr_o SHALL be 8'h00 and ram_addr_o SHALL hold its last value.
REQ-019 A 1-cycle response pipeline register SHALL record the owner of each accept; the owner's resp_valid_o SHALL pulse exactly one cycle after accept, for reads and writes alike.
REQ-020 resp_data_o SHALL equal ram_data_i in the response cycle; for writes this is the pre-write (read-first) word; non-owner resp_data_o SHALL be 0.
REQ-021 Back-to-back accepts SHALL be supported at 1 per cycle, no bubbles, including alternating A/B.
REQ-022 Throughput guarantee: with both ports continuously valid and b_lock_i=0, B SHALL receive 1 accept per STARVE_LIMIT+1 cycles.
REQ-023 Addresses SHALL pass unmodified; no address wrap or range check.

Reset
REQ-024 While rst_i=0: state = ARB_NORMAL, starve_cnt = 0, response pipe empty, ram_addr_o = 0, ram_wr_o = 0, all accept/resp_valid_o = 0, resp_data_o = 0.
REQ-025 Reset asserted mid-transaction SHALL drop any pending response (no resp_valid_o after deassertion) and clear a held lock.
REQ-026 First accept SHALL be possible in the first clock edge after rst_i deasserts.

Verification
REQ-027 A-only read addr 0x0010 after write 0xDEADBEEF_01234567 wr=0xFF -> accept same cycle, a_resp_valid_o next cycle, read returns 0xDEADBEEF_01234567.
REQ-028 A and B both valid continuously, STARVE_LIMIT=4 -> B accepted on every 5th cycle, starve_cnt returns to 0 after each B accept.
REQ-029 B write wr=0x0F with b_lock_i=1, then B read same addr, with A valid throughout -> A refused both cycles, then A accepted; b_resp_data_o shows pre-write word then merged word.
REQ-030 B holds lock with A valid for 4 cycles (STARVE_LIMIT=4) -> lock forcibly released, A accepted in cycle 5.
REQ-031 Alternating A write / B read to same address, back-to-back -> B sees A's data, read-first ordering, no dropped responses.
REQ-032 rst_i pulsed low the cycle after an accept -> no resp_valid_o afterwards, all outputs at reset values, normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/tcm_port_arb.sv
// Two-port arbiter for a shared single-port TCM: CPU (A) has priority, DMA (B) is
// protected by a starvation counter and may lock the port for an atomic RMW pair.
module tcm_port_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_valid_i,
    input  logic [12:0] a_addr_i,
    input  logic [63:0] a_data_i,
    input  logic [7:0]  a_wr_i,
    output logic        a_accept_o,
    output logic        a_resp_valid_o,
    output logic [63:0] a_resp_data_o,
    input  logic        b_valid_i,
    input  logic [12:0] b_addr_i,
    input  logic [63:0] b_data_i,
    input  logic [7:0]  b_wr_i,
    input  logic        b_lock_i,
    output logic        b_accept_o,
    output logic        b_resp_valid_o,
    output logic [63:0] b_resp_data_o,
    output logic [12:0] ram_addr_o,
    output logic [63:0] ram_data_o,
    output logic [7:0]  ram_wr_o,
    input  logic [63:0] ram_data_i
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {ARB_NORMAL, ARB_B_LOCK} arb_state_e;

    arb_state_e  r_state;
    logic [7:0]  r_starve_cnt;
    logic [7:0]  r_lock_cnt;
    logic [12:0] r_last_addr;
    logic        r_resp_a;
    logic        r_resp_b;
    logic        w_a_acc;
    logic        w_b_acc;
    logic        w_lock_expire;

    // Accepts are gated by reset so nothing reaches the RAM while rst_i is low.
    always_comb begin
        w_a_acc = 1'b0;
        w_b_acc = 1'b0;
        if (rst_i) begin
            if (r_state == ARB_B_LOCK) begin
                w_b_acc = b_valid_i;
            end else begin
                w_b_acc = b_valid_i && (!a_valid_i || r_starve_cnt == LIMIT);
                w_a_acc = a_valid_i && !w_b_acc;
            end
        end
    end

    assign a_accept_o = w_a_acc;
    assign b_accept_o = w_b_acc;

    always_comb begin
        ram_addr_o = r_last_addr;
        ram_data_o = 64'h0;
        ram_wr_o   = 8'h00;
        if (w_b_acc) begin
            ram_addr_o = b_addr_i;
            ram_data_o = b_data_i;
            ram_wr_o   = b_wr_i;
        end else if (w_a_acc) begin
            ram_addr_o = a_addr_i;
            ram_data_o = a_data_i;
            ram_wr_o   = a_wr_i;
        end
    end

    // Lock is released after LIMIT consecutive locked cycles that A spent waiting.
    assign w_lock_expire = a_valid_i && (r_lock_cnt == LIMIT - 8'd1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ARB_NORMAL;
            r_starve_cnt <= 8'd0;
            r_lock_cnt   <= 8'd0;
            r_last_addr  <= 13'd0;
            r_resp_a     <= 1'b0;
            r_resp_b     <= 1'b0;
        end else begin
            r_resp_a <= w_a_acc;
            r_resp_b <= w_b_acc;
            if (w_a_acc || w_b_acc)
                r_last_addr <= ram_addr_o;
            if (b_valid_i && !w_b_acc)
                r_starve_cnt <= (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + 8'd1;
            else
                r_starve_cnt <= 8'd0;
            case (r_state)
                ARB_NORMAL: begin
                    r_lock_cnt <= 8'd0;
                    if (w_b_acc && b_lock_i)
                        r_state <= ARB_B_LOCK;
                end
                ARB_B_LOCK: begin
                    r_lock_cnt <= a_valid_i ? r_lock_cnt + 8'd1 : 8'd0;
                    if (!b_valid_i || (w_b_acc && !b_lock_i) || w_lock_expire) begin
                        r_state    <= ARB_NORMAL;
                        r_lock_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_state    <= ARB_NORMAL;
                    r_lock_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign a_resp_valid_o = r_resp_a;
    assign b_resp_valid_o = r_resp_b;
    assign a_resp_data_o  = r_resp_a ? ram_data_i : 64'h0;
    assign b_resp_data_o  = r_resp_b ? ram_data_i : 64'h0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed + random bench for tcm_port_arb with a read-first RAM and a
// cycle-level reference model of the arbitration rules.
module tb_tcm_port_arb;
    localparam int L = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        a_valid_i = 1'b0, b_valid_i = 1'b0, b_lock_i = 1'b0;
    logic [12:0] a_addr_i = '0, b_addr_i = '0;
    logic [63:0] a_data_i = '0, b_data_i = '0;
    logic [7:0]  a_wr_i = '0, b_wr_i = '0;
    logic        a_accept_o, b_accept_o, a_resp_valid_o, b_resp_valid_o;
    logic [63:0] a_resp_data_o, b_resp_data_o, ram_data_o;
    logic [12:0] ram_addr_o;
    logic [7:0]  ram_wr_o;
    logic [63:0] ram_data_i = '0;

    always #5 clk_i = ~clk_i;

    tcm_port_arb #(.STARVE_LIMIT(L)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_wr_i(a_wr_i),
        .a_accept_o(a_accept_o), .a_resp_valid_o(a_resp_valid_o), .a_resp_data_o(a_resp_data_o),
        .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_wr_i(b_wr_i),
        .b_lock_i(b_lock_i),
        .b_accept_o(b_accept_o), .b_resp_valid_o(b_resp_valid_o), .b_resp_data_o(b_resp_data_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
        .ram_data_i(ram_data_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mem     [0:8191];
    logic [63:0] ref_mem [0:8191];

    // Reference model state
    bit          m_lock;
    int          m_starve, m_run;
    logic [12:0] m_last;
    bit          e_ra, e_rb;
    logic [63:0] e_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_starve = 0; m_run = 0; m_last = '0;
        e_ra = 0; e_rb = 0; e_rdata = '0;
    endtask

    // Holds reset across two edges with both ports requesting, then releases
    // mid-high-phase so the following edge is the first one out of reset.
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        a_valid_i = 1'b1; b_valid_i = 1'b1; a_wr_i = 8'hFF; b_wr_i = 8'hFF; b_lock_i = 1'b1;
        a_addr_i = 13'h55; b_addr_i = 13'h66;
        #1;
        chk("rst_a_accept", 64'(a_accept_o), 64'(0));
        chk("rst_b_accept", 64'(b_accept_o), 64'(0));
        chk("rst_a_resp_valid", 64'(a_resp_valid_o), 64'(0));
        chk("rst_b_resp_valid", 64'(b_resp_valid_o), 64'(0));
        chk("rst_a_resp_data", a_resp_data_o, 64'(0));
        chk("rst_b_resp_data", b_resp_data_o, 64'(0));
        chk("rst_ram_wr", 64'(ram_wr_o), 64'(0));
        chk("rst_ram_addr", 64'(ram_addr_o), 64'(0));
        @(posedge clk_i);
        @(posedge clk_i);
        a_valid_i = 1'b0; b_valid_i = 1'b0; a_wr_i = '0; b_wr_i = '0; b_lock_i = 1'b0;
        #2 rst_i = 1'b1;
        model_reset();
    endtask

    task automatic cyc(input bit av, input logic [12:0] aa, input logic [63:0] ad, input logic [7:0] aw,
                       input bit bv, input logic [12:0] ba, input logic [63:0] bd, input logic [7:0] bw,
                       input bit lk);
        bit          ga, gb;
        logic [12:0] xa, cap_a;
        logic [63:0] xd, cap_d;
        logic [7:0]  xw, cap_w;
        @(negedge clk_i);
        a_valid_i = av; a_addr_i = aa; a_data_i = ad; a_wr_i = aw;
        b_valid_i = bv; b_addr_i = ba; b_data_i = bd; b_wr_i = bw; b_lock_i = lk;
        #1;
        chk("a_resp_valid", 64'(a_resp_valid_o), 64'(e_ra));
        chk("b_resp_valid", 64'(b_resp_valid_o), 64'(e_rb));
        chk("a_resp_data", a_resp_data_o, e_ra ? e_rdata : 64'h0);
        chk("b_resp_data", b_resp_data_o, e_rb ? e_rdata : 64'h0);
        if (m_lock) begin
            gb = bv; ga = 0;
        end else begin
            gb = bv && (!av || m_starve == L);
            ga = av && !gb;
        end
        chk("a_accept", 64'(a_accept_o), 64'(ga));
        chk("b_accept", 64'(b_accept_o), 64'(gb));
        if (ga || gb) begin
            xa = gb ? ba : aa; xd = gb ? bd : ad; xw = gb ? bw : aw;
            chk("ram_addr", 64'(ram_addr_o), 64'(xa));
            chk("ram_wr", 64'(ram_wr_o), 64'(xw));
            chk("ram_data", ram_data_o, xd);
            e_rdata = ref_mem[xa];
            for (int k = 0; k < 8; k++)
                if (xw[k]) ref_mem[xa][8*k +: 8] = xd[8*k +: 8];
            m_last = xa;
        end else begin
            chk("ram_addr_hold", 64'(ram_addr_o), 64'(m_last));
            chk("ram_wr_idle", 64'(ram_wr_o), 64'(0));
        end
        e_ra = ga; e_rb = gb;
        if (bv && !gb) m_starve = (m_starve == L) ? L : m_starve + 1;
        else           m_starve = 0;
        if (!m_lock) begin
            m_lock = gb && lk;
            m_run  = 0;
        end else begin
            m_run = av ? m_run + 1 : 0;
            if (!bv || (gb && !lk) || m_run == L) begin
                m_lock = 0; m_run = 0;
            end
        end
        cap_a = ram_addr_o; cap_d = ram_data_o; cap_w = ram_wr_o;
        @(posedge clk_i);
        ram_data_i = mem[cap_a];
        for (int k = 0; k < 8; k++)
            if (cap_w[k]) mem[cap_a][8*k +: 8] = cap_d[8*k +: 8];
    endtask

    task automatic idle();
        cyc(0, '0, '0, '0, 0, '0, '0, '0, 0);
    endtask

    initial begin
        int b_grants;
        for (int i = 0; i < 8192; i++) begin
            mem[i] = '0; ref_mem[i] = '0;
        end
        model_reset();
        do_reset();

        // A write then read at 0x0010, first accept on the first edge out of reset
        cyc(1, 13'h0010, 64'hDEADBEEF_01234567, 8'hFF, 0, '0, '0, '0, 0);
        cyc(1, 13'h0010, 64'h0, 8'h00, 0, '0, '0, '0, 0);
        #1 chk("req027_rdata", a_resp_data_o, 64'hDEADBEEF_01234567);
        idle();

        // Both ports continuously valid: B every 5th cycle
        b_grants = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1, 13'(i), '0, '0, 1, 13'(i + 100), '0, '0, 0);
            #1 if (b_resp_valid_o) b_grants++;
        end
        chk("req028_b_grants", 64'(b_grants), 64'(3));
        idle();

        // Locked RMW by B while A is continuously valid
        cyc(1, 13'h0020, 64'hAAAABBBB_CCCCDDDD, 8'hFF, 0, '0, '0, '0, 0);
        for (int i = 0; i < 10 && !m_lock; i++)
            cyc(1, 13'h0005, '0, '0, 1, 13'h0020, 64'h11112222_33334444, 8'h0F, 1);
        #1 chk("req029_pre_write", b_resp_data_o, 64'hAAAABBBB_CCCCDDDD);
        cyc(1, 13'h0005, '0, '0, 1, 13'h0020, '0, 8'h00, 0);
        #1 chk("req029_merged", b_resp_data_o, 64'hAAAABBBB_33334444);
        cyc(1, 13'h0005, '0, '0, 0, '0, '0, '0, 0);
        idle();

        // Lock held with A waiting: forced release
        for (int i = 0; i < 14; i++)
            cyc(1, 13'h0007, '0, '0, 1, 13'h0008, '0, '0, 1);
        idle();

        // Alternating A write / B read to the same word, plus top address
        for (int i = 0; i < 4; i++) begin
            cyc(1, 13'h0003, {32'(i), 32'hCAFE0000}, 8'hFF, 0, '0, '0, '0, 0);
            cyc(0, '0, '0, '0, 1, 13'h0003, '0, 8'h00, 0);
        end
        cyc(1, 13'h1FFF, 64'h0123456789ABCDEF, 8'hF0, 0, '0, '0, '0, 0);
        cyc(0, '0, '0, '0, 1, 13'h1FFF, '0, 8'h00, 0);
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, 13'($urandom % 16), {$urandom, $urandom},
                ($urandom % 2) ? 8'($urandom) : 8'h00,
                ($urandom % 3) != 0, 13'($urandom % 16), {$urandom, $urandom},
                ($urandom % 2) ? 8'($urandom) : 8'h00,
                ($urandom % 4) == 0);
        end

        // Reset right after an accept, while B holds a lock
        for (int i = 0; i < 10 && !m_lock; i++)
            cyc(0, '0, '0, '0, 1, 13'h0009, '0, '0, 1);
        cyc(1, 13'h0010, '0, 8'h00, 1, 13'h0009, '0, '0, 1);
        do_reset();
        cyc(1, 13'h0010, '0, 8'h00, 1, 13'h0009, '0, '0, 0);
        cyc(1, 13'h0010, '0, 8'h00, 0, '0, '0, '0, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
